// File: rtl/fir_mac_unit.sv
// fir_mac_unit: signed 32x32 multiply-accumulate for the FIR extension of the core.
// Latency: operands captured at edge 0, 32 shift-add edges, write-back pulse after edge 33, idle after edge 34.
// Backpressure: none; busy stalls the core and start is ignored until the unit is back in IDLE.
module fir_mac_unit #(
  parameter int SATURATE = 1,
  parameter int SHIFT    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [4:0]  rd_in,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] accIn,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        fir_we,
  output logic [4:0]  fir_waddr,
  output logic [31:0] fir_wdata
);

  typedef enum logic [1:0] {IDLE, MUL, ACC, WB} state_t;

  state_t        state, state_nxt;
  logic [4:0]    iter_cnt;
  logic [63:0]   product;
  logic [63:0]   mcand;
  logic [31:0]   mplier;
  logic          prod_neg;
  logic [31:0]   acc_q;
  logic [4:0]    rd_q;

  logic          do_capture, do_iter, do_acc, do_clear;
  logic [31:0]   mag_a, mag_b;
  logic signed [64:0] prod_signed, prod_shifted, acc_ext, sum;
  logic          sum_ovf;
  logic [31:0]   result;

  // Magnitudes as unsigned 32-bit; 0x80000000 negates to itself, which reads as 2^31.
  assign mag_a = opA[31] ? (~opA + 32'd1) : opA;
  assign mag_b = opB[31] ? (~opB + 32'd1) : opB;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic: one capture edge, 32 multiply edges, one accumulate edge, one write-back edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MUL;
      MUL:     if (iter_cnt == 5'd31) state_nxt = ACC;
      ACC:     state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-state control strobes for the datapath register block.
  always_comb begin
    do_capture = 1'b0;
    do_iter    = 1'b0;
    do_acc     = 1'b0;
    do_clear   = 1'b0;
    case (state)
      IDLE:    do_capture = start;
      MUL:     do_iter    = 1'b1;
      ACC:     do_acc     = 1'b1;
      WB:      do_clear   = 1'b1;
      default: do_clear   = 1'b1;
    endcase
  end

  // Apply sign, Q-format shift and accumulate at 65 bits, then saturate or wrap.
  always_comb begin
    prod_signed  = prod_neg ? -$signed({1'b0, product}) : $signed({1'b0, product});
    prod_shifted = prod_signed >>> SHIFT;
    acc_ext      = $signed({{33{acc_q[31]}}, acc_q});
    sum          = prod_shifted + acc_ext;
    // In range iff bits 64..31 are all copies of the sign.
    sum_ovf      = !((&sum[64:31]) || (~|sum[64:31]));
    result       = sum[31:0];
    if (SATURATE != 0 && sum_ovf) result = sum[64] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  end

  // Datapath and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      iter_cnt  <= '0;
      product   <= '0;
      mcand     <= '0;
      mplier    <= '0;
      prod_neg  <= 1'b0;
      acc_q     <= '0;
      rd_q      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      fir_we    <= 1'b0;
      fir_waddr <= '0;
      fir_wdata <= '0;
    end else begin
      if (do_capture) begin
        mcand    <= {32'd0, mag_a};
        mplier   <= mag_b;
        product  <= '0;
        prod_neg <= opA[31] ^ opB[31];
        acc_q    <= accIn;
        rd_q     <= rd_in;
        iter_cnt <= '0;
        busy     <= 1'b1;
      end
      if (do_iter) begin
        if (mplier[0]) product <= product + mcand;
        mcand    <= mcand << 1;
        mplier   <= mplier >> 1;
        iter_cnt <= iter_cnt + 5'd1;
      end
      if (do_acc) begin
        done      <= 1'b1;
        fir_we    <= (rd_q != 5'd0);
        fir_waddr <= rd_q;
        fir_wdata <= result;
        ovf       <= sum_ovf;
      end
      if (do_clear) begin
        done   <= 1'b0;
        fir_we <= 1'b0;
        busy   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_mac_unit.sv
// Bench for fir_mac_unit: three instances (default, wrapping, Q15-shifted) share one stimulus.
// Results are compared against a plain-arithmetic reference model.
module tb_fir_mac_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  rd_in = '0;
  logic [31:0] opA = '0, opB = '0, accIn = '0;

  logic        d_busy, d_done, d_ovf, d_fir_we;
  logic [4:0]  d_fir_waddr;
  logic [31:0] d_fir_wdata;
  logic        w_busy, w_done, w_ovf, w_fir_we;
  logic [4:0]  w_fir_waddr;
  logic [31:0] w_fir_wdata;
  logic        q_busy, q_done, q_ovf, q_fir_we;
  logic [4:0]  q_fir_waddr;
  logic [31:0] q_fir_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  fir_mac_unit dut (
    .clock(clock), .reset(reset), .start(start), .rd_in(rd_in),
    .opA(opA), .opB(opB), .accIn(accIn),
    .busy(d_busy), .done(d_done), .ovf(d_ovf), .fir_we(d_fir_we),
    .fir_waddr(d_fir_waddr), .fir_wdata(d_fir_wdata)
  );

  fir_mac_unit #(.SATURATE(0), .SHIFT(0)) dut_wrap (
    .clock(clock), .reset(reset), .start(start), .rd_in(rd_in),
    .opA(opA), .opB(opB), .accIn(accIn),
    .busy(w_busy), .done(w_done), .ovf(w_ovf), .fir_we(w_fir_we),
    .fir_waddr(w_fir_waddr), .fir_wdata(w_fir_wdata)
  );

  fir_mac_unit #(.SATURATE(1), .SHIFT(15)) dut_q15 (
    .clock(clock), .reset(reset), .start(start), .rd_in(rd_in),
    .opA(opA), .opB(opB), .accIn(accIn),
    .busy(q_busy), .done(q_done), .ovf(q_ovf), .fir_we(q_fir_we),
    .fir_waddr(q_fir_waddr), .fir_wdata(q_fir_wdata)
  );

  // Reference: exact signed product, shift, add, then clamp or wrap. Returns {ovf, result}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] acc, input int sat, input int sh);
    longint p, s;
    logic   o;
    logic [31:0] r;
    p = longint'($signed(a)) * longint'($signed(b));
    p = p >>> sh;
    s = p + longint'($signed(acc));
    o = (s > longint'(32'sh7FFF_FFFF)) || (s < longint'(32'sh8000_0000));
    r = s[31:0];
    if (sat != 0 && o) r = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    return {o, r};
  endfunction

  // Present one request for exactly one edge (edge 0), then scramble the operand inputs.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                        input logic [4:0] rd);
    @(negedge clock);
    opA = a; opB = b; accIn = acc; rd_in = rd; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    opA = $urandom; opB = $urandom; accIn = $urandom; rd_in = 5'($urandom);
  endtask

  // Count edges until done, bounded; lat stays -1 if done never arrives.
  task automatic wait_done(output int lat, output int we_cnt, output int busy_low);
    lat = -1; we_cnt = 0; busy_low = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge clock);
      #1;
      if (d_fir_we) we_cnt++;
      if (!d_busy) busy_low++;
      if (d_done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; opA = 32'd3; opB = 32'd4; accIn = 32'd10; rd_in = 5'd5;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", d_busy); end
    checks++; if (d_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", d_done); end
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", d_ovf); end
    checks++; if (d_fir_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", d_fir_we); end
    checks++; if (d_fir_waddr !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", d_fir_waddr); end
    checks++; if (d_fir_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got %h want 0", d_fir_wdata); end
    start = 1'b0; reset = 1'b0;
    @(posedge clock);
    #1;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy got %b want 0", d_busy); end
  endtask

  task automatic test_basic;
    int lat, we_cnt, busy_low;
    launch(32'd3, 32'd4, 32'd10, 5'd5);
    checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL basic_busy_edge0 got %b want 1", d_busy); end
    wait_done(lat, we_cnt, busy_low);
    checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
    checks++; if (busy_low !== 0) begin errors++; $display("FAIL basic_busy_gap got %0d want 0", busy_low); end
    checks++; if (we_cnt !== 1 || d_fir_we !== 1'b1) begin errors++; $display("FAIL basic_we got cnt %0d we %b want 1 1", we_cnt, d_fir_we); end
    checks++; if (d_fir_waddr !== 5'd5) begin errors++; $display("FAIL basic_waddr got %0d want 5", d_fir_waddr); end
    checks++; if (d_fir_wdata !== 32'd22) begin errors++; $display("FAIL basic_wdata got %0d want 22", d_fir_wdata); end
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b want 0", d_ovf); end
    @(posedge clock);
    #1;
    checks++; if ({d_fir_we, d_done, d_busy} !== 3'b000) begin errors++; $display("FAIL basic_wb_clear got %b want 000", {d_fir_we, d_done, d_busy}); end
    @(posedge clock);
    #1;
    checks++; if (d_fir_waddr !== 5'd5 || d_fir_wdata !== 32'd22) begin errors++; $display("FAIL basic_hold got %0d %0d want 5 22", d_fir_waddr, d_fir_wdata); end
  endtask

  task automatic test_signed;
    int lat, we_cnt, busy_low;
    launch(32'hFFFF_FFF9, 32'd6, 32'd0, 5'd7);
    wait_done(lat, we_cnt, busy_low);
    checks++; if (d_fir_wdata !== 32'hFFFF_FFD6) begin errors++; $display("FAIL signed_wdata got %h want ffffffd6", d_fir_wdata); end
    checks++; if (d_ovf !== 1'b0) begin errors++; $display("FAIL signed_ovf got %b want 0", d_ovf); end
    @(posedge clock);
  endtask

  task automatic test_overflow;
    int lat, we_cnt, busy_low;
    launch(32'h7FFF_FFFF, 32'd2, 32'd0, 5'd1);
    wait_done(lat, we_cnt, busy_low);
    checks++; if (d_fir_wdata !== 32'h7FFF_FFFF || d_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat got %h %b want 7fffffff 1", d_fir_wdata, d_ovf); end
    checks++; if (w_fir_wdata !== 32'hFFFF_FFFE || w_ovf !== 1'b1) begin errors++; $display("FAIL ovf_wrap got %h %b want fffffffe 1", w_fir_wdata, w_ovf); end
    @(posedge clock);
  endtask

  task automatic test_q15;
    int lat, we_cnt, busy_low;
    launch(32'h4000, 32'h4000, 32'h100, 5'd2);
    wait_done(lat, we_cnt, busy_low);
    checks++; if (q_fir_wdata !== 32'h2100 || q_ovf !== 1'b0) begin errors++; $display("FAIL q15_wdata got %h %b want 00002100 0", q_fir_wdata, q_ovf); end
    @(posedge clock);
  endtask

  task automatic test_most_negative;
    int lat, we_cnt, busy_low;
    logic [32:0] ed, ew, eq;
    ed = model(32'h8000_0000, 32'h8000_0000, 32'd0, 1, 0);
    ew = model(32'h8000_0000, 32'h8000_0000, 32'd0, 0, 0);
    eq = model(32'h8000_0000, 32'h8000_0000, 32'd0, 1, 15);
    launch(32'h8000_0000, 32'h8000_0000, 32'd0, 5'd3);
    wait_done(lat, we_cnt, busy_low);
    checks++; if ({d_ovf, d_fir_wdata} !== ed) begin errors++; $display("FAIL mostneg_sat got %h want %h", {d_ovf, d_fir_wdata}, ed); end
    checks++; if ({w_ovf, w_fir_wdata} !== ew) begin errors++; $display("FAIL mostneg_wrap got %h want %h", {w_ovf, w_fir_wdata}, ew); end
    checks++; if ({q_ovf, q_fir_wdata} !== eq) begin errors++; $display("FAIL mostneg_q15 got %h want %h", {q_ovf, q_fir_wdata}, eq); end
    @(posedge clock);
  endtask

  task automatic test_zero;
    int lat, we_cnt, busy_low;
    logic [31:0] a, b, acc;
    for (int i = 0; i < 4; i++) begin
      a = (i % 2 == 0) ? 32'd0 : $urandom;
      b = (i % 2 == 0) ? $urandom : 32'd0;
      acc = $urandom;
      launch(a, b, acc, 5'd4);
      wait_done(lat, we_cnt, busy_low);
      checks++; if (d_fir_wdata !== acc || d_ovf !== 1'b0) begin errors++; $display("FAIL zero_op%0d got %h %b want %h 0", i, d_fir_wdata, d_ovf, acc); end
      @(posedge clock);
    end
  endtask

  task automatic test_ignored_start;
    int lat, we_cnt, busy_low, extra;
    logic [32:0] e;
    e = model(32'd1234, 32'hFFFF_FF00, 32'd77, 1, 0);
    launch(32'd1234, 32'hFFFF_FF00, 32'd77, 5'd12);
    repeat (9) @(posedge clock);
    @(negedge clock);
    opA = 32'd100; opB = 32'd100; accIn = 32'd5; rd_in = 5'd9; start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    wait_done(lat, we_cnt, busy_low);
    checks++; if (lat !== 23) begin errors++; $display("FAIL ignore_latency got %0d want 23", lat); end
    checks++; if ({d_ovf, d_fir_wdata} !== e || d_fir_waddr !== 5'd12) begin errors++; $display("FAIL ignore_result got %h rd %0d want %h rd 12", {d_ovf, d_fir_wdata}, d_fir_waddr, e); end
    @(posedge clock);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (d_done || d_busy) extra++;
    end
    checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_queue got %0d want 0", extra); end
  endtask

  task automatic test_rd_zero;
    int lat, we_cnt, busy_low;
    launch(32'd9, 32'd9, 32'd1, 5'd0);
    wait_done(lat, we_cnt, busy_low);
    checks++; if (lat !== 33 || d_done !== 1'b1) begin errors++; $display("FAIL rd0_done got lat %0d want 33", lat); end
    checks++; if (we_cnt !== 0 || d_fir_we !== 1'b0) begin errors++; $display("FAIL rd0_we got %0d want 0", we_cnt); end
    checks++; if (d_fir_wdata !== 32'd82) begin errors++; $display("FAIL rd0_wdata got %0d want 82", d_fir_wdata); end
    @(posedge clock);
  endtask

  task automatic test_reset_mid;
    int lat, we_cnt, busy_low, pulses;
    launch(32'd3, 32'd4, 32'd10, 5'd5);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checks++; if (d_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", d_busy); end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (d_done || d_fir_we) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL rstmid_no_wb got %0d want 0", pulses); end
    launch(32'd3, 32'd4, 32'd10, 5'd5);
    wait_done(lat, we_cnt, busy_low);
    checks++; if (lat !== 33 || d_fir_wdata !== 32'd22 || d_fir_we !== 1'b1) begin errors++; $display("FAIL rstmid_fresh got lat %0d wdata %0d want 33 22", lat, d_fir_wdata); end
    @(posedge clock);
  endtask

  task automatic test_back_to_back;
    int lat, we_cnt, busy_low;
    logic [31:0] a, b, acc;
    logic [4:0]  rd;
    logic [32:0] ed, ew, eq;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = 32'($signed($urandom_range(0, 2000)) - 1000); b = 32'($signed($urandom_range(0, 2000)) - 1000); end
        2: begin a = ($urandom_range(0, 1) != 0) ? 32'h8000_0000 : 32'h7FFF_FFFF; b = $urandom; end
        default: begin a = $urandom_range(0, 32'hFFFF); b = $urandom_range(0, 32'hFFFF); end
      endcase
      acc = $urandom;
      rd  = 5'($urandom);
      ed = model(a, b, acc, 1, 0);
      ew = model(a, b, acc, 0, 0);
      eq = model(a, b, acc, 1, 15);
      launch(a, b, acc, rd);
      checks++; if (d_busy !== 1'b1) begin errors++; $display("FAIL b2b%0d_busy got %b want 1", n, d_busy); end
      wait_done(lat, we_cnt, busy_low);
      checks++; if (lat !== 33) begin errors++; $display("FAIL b2b%0d_latency got %0d want 33", n, lat); end
      checks++; if ({d_ovf, d_fir_wdata} !== ed) begin errors++; $display("FAIL b2b%0d_sat got %h want %h", n, {d_ovf, d_fir_wdata}, ed); end
      checks++; if ({w_ovf, w_fir_wdata} !== ew || w_done !== 1'b1) begin errors++; $display("FAIL b2b%0d_wrap got %h want %h", n, {w_ovf, w_fir_wdata}, ew); end
      checks++; if ({q_ovf, q_fir_wdata} !== eq || q_done !== 1'b1) begin errors++; $display("FAIL b2b%0d_q15 got %h want %h", n, {q_ovf, q_fir_wdata}, eq); end
      checks++; if ({d_fir_we, w_fir_we, q_fir_we} !== {3{rd != 5'd0}}) begin errors++; $display("FAIL b2b%0d_we got %b want %b", n, {d_fir_we, w_fir_we, q_fir_we}, {3{rd != 5'd0}}); end
      checks++; if (d_fir_waddr !== rd || w_fir_waddr !== rd || q_fir_waddr !== rd) begin errors++; $display("FAIL b2b%0d_waddr got %0d %0d %0d want %0d", n, d_fir_waddr, w_fir_waddr, q_fir_waddr, rd); end
      @(posedge clock);
      #1;
      checks++; if ({d_busy, w_busy, q_busy, d_fir_we} !== 4'b0000) begin errors++; $display("FAIL b2b%0d_idle got %b want 0000", n, {d_busy, w_busy, q_busy, d_fir_we}); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_q15();
    test_most_negative();
    test_zero();
    test_ignored_start();
    test_rd_zero();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
